// File: rtl/instr_word_encoder_if.sv
// Handshake bundles for the instruction word encoder:
// field-level instruction input and the IMEM write bus.
interface instr_word_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_fmt;
    logic [5:0]  in_op;
    logic [5:0]  in_func;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        in_last;

    modport master (
        output in_valid, in_fmt, in_op, in_func,
        output in_rs, in_rt, in_rd, in_shamt,
        output in_imm, in_target, in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_fmt, in_op, in_func,
        input  in_rs, in_rt, in_rd, in_shamt,
        input  in_imm, in_target, in_last,
        output in_ready
    );
endinterface

interface imem_wr_if #(
    parameter int ADDR_W = 8
);
    logic              imem_we;
    logic              imem_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output imem_we, imem_addr, imem_wdata,
        input  imem_ready
    );

    modport slave (
        input  imem_we, imem_addr, imem_wdata,
        output imem_ready
    );
endinterface

// File: rtl/instr_word_encoder.sv
// Packs field-level MIPS instruction descriptions into 32-bit words,
// buffers them in a FIFO and writes them to IMEM at consecutive addresses.
module instr_word_encoder #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    instr_word_encoder_if.slave in_if,
    imem_wr_if.master           mem_if,
    output logic                busy,
    output logic                done,
    output logic                err_illegal,
    output logic [ADDR_W:0]     word_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       mem_q [DEPTH];
    logic [PW:0]       wptr_q, rptr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   cnt_q;
    logic              err_q;

    logic        fifo_empty, fifo_full, active;
    logic        fire, push, pop, start_ok;
    logic        legal;
    logic [31:0] word;

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[PW] != rptr_q[PW]) &&
                        (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign active     = (state_q == S_RUN) || (state_q == S_DRAIN);

    assign in_if.in_ready = (state_q == S_RUN) && !fifo_full;
    assign fire     = in_if.in_valid && in_if.in_ready;
    assign push     = fire && legal;
    assign start_ok = start &&
                      ((state_q == S_IDLE) || (state_q == S_DONE));

    assign mem_if.imem_we    = !fifo_empty && active;
    assign mem_if.imem_addr  = addr_q;
    assign mem_if.imem_wdata = mem_q[rptr_q[PW-1:0]];
    assign pop = mem_if.imem_we && mem_if.imem_ready;

    assign busy        = active;
    assign done        = (state_q == S_DONE);
    assign err_illegal = err_q;
    assign word_count  = cnt_q;

    // Field packing and legality check for the offered instruction
    always_comb begin
        word  = 32'h0;
        legal = 1'b0;
        unique case (in_if.in_fmt)
            2'd0: begin
                word  = {6'b0, in_if.in_rs, in_if.in_rt, in_if.in_rd,
                         in_if.in_shamt, in_if.in_func};
                legal = (in_if.in_op == 6'd0);
            end
            2'd1: begin
                word  = {in_if.in_op, in_if.in_rs, in_if.in_rt,
                         in_if.in_imm};
                legal = 1'b1;
            end
            2'd2: begin
                word  = {in_if.in_op, in_if.in_target};
                legal = 1'b1;
            end
            default: begin
                word  = 32'h0;
                legal = 1'b0;
            end
        endcase
    end

    // Next-state logic of the load sequencer
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                if (fire && in_if.in_last) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (fifo_empty) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FIFO storage; contents are don't-care while the pointers say empty
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[PW-1:0]] <= word;
    end

    // FIFO pointers, write address, word counter and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            addr_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + (PW+1)'(1);
            if (pop)  rptr_q <= rptr_q + (PW+1)'(1);
            if (start_ok) begin
                addr_q <= base_addr;
                cnt_q  <= '0;
                err_q  <= 1'b0;
            end else begin
                if (pop) begin
                    addr_q <= addr_q + ADDR_W'(1);
                    if (cnt_q != CNT_MAX) cnt_q <= cnt_q + (ADDR_W+1)'(1);
                end
                if (fire && !legal) err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_word_encoder.sv
// Scoreboard bench for instr_word_encoder: driver queues expected IMEM
// writes, a negedge monitor pops and compares every accepted write.
module tb_instr_word_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] base_addr;
    logic       busy, done, err_illegal;
    logic [8:0] word_count;

    instr_word_encoder_if in_if ();
    imem_wr_if #(.ADDR_W(8)) mem_if ();

    instr_word_encoder #(.ADDR_W(8), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .in_if      (in_if),
        .mem_if     (mem_if),
        .busy       (busy),
        .done       (done),
        .err_illegal(err_illegal),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [39:0] sb[$];
    logic [7:0]  exp_addr;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted IMEM write must match the scoreboard head
    always @(negedge clk) begin
        if (!rst && mem_if.imem_we && mem_if.imem_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0h data %0h",
                         mem_if.imem_addr, mem_if.imem_wdata);
            end else begin
                logic [39:0] e;
                e = sb.pop_front();
                chk("wr_addr", 64'(mem_if.imem_addr), 64'(e[39:32]));
                chk("wr_data", 64'(mem_if.imem_wdata), 64'(e[31:0]));
            end
        end
    end

    task automatic do_start(input logic [7:0] base);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = base;
        exp_addr = base;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [1:0] fmt, input logic [5:0] op,
                        input logic [5:0] func, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd,
                        input logic [15:0] imm, input logic [25:0] tgt,
                        input logic last, input bit exp_wr,
                        input logic [31:0] exp_word);
        bit ok;
        in_if.in_fmt = fmt;
        in_if.in_op = op;
        in_if.in_func = func;
        in_if.in_rs = rs;
        in_if.in_rt = rt;
        in_if.in_rd = rd;
        in_if.in_shamt = 5'd0;
        in_if.in_imm = imm;
        in_if.in_target = tgt;
        in_if.in_last = last;
        in_if.in_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (in_if.in_ready) ok = 1'b1;
        end
        if (!ok) chk("handshake_timeout", 0, 1);
        else if (exp_wr) begin
            sb.push_back({exp_addr, exp_word});
            exp_addr = exp_addr + 8'd1;
        end
        @(posedge clk); #1;
        in_if.in_valid = 1'b0;
        in_if.in_last = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk(name, 64'(seen), 1);
    endtask

    logic [7:0]  snap_addr;
    logic [31:0] snap_data;
    int          accepted;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        base_addr = 8'h0;
        exp_addr = 8'h0;
        in_if.in_valid = 1'b0;
        in_if.in_fmt = 2'd0;
        in_if.in_op = 6'd0;
        in_if.in_func = 6'd0;
        in_if.in_rs = 5'd0;
        in_if.in_rt = 5'd0;
        in_if.in_rd = 5'd0;
        in_if.in_shamt = 5'd0;
        in_if.in_imm = 16'd0;
        in_if.in_target = 26'd0;
        in_if.in_last = 1'b0;
        mem_if.imem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_we", 64'(mem_if.imem_we), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_err", 64'(err_illegal), 0);
        chk("rst_cnt", 64'(word_count), 0);
        chk("rst_ready", 64'(in_if.in_ready), 0);
        chk("rst_addr", 64'(mem_if.imem_addr), 0);

        // R-type add $3,$1,$2
        do_start(8'h10);
        chk("run_busy", 64'(busy), 1);
        send(2'd0, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0,
             1'b1, 1'b1, 32'h0022_1820);
        chk("latency_we", 64'(mem_if.imem_we), 1);
        wait_done("done_add");
        chk("cnt_add", 64'(word_count), 1);
        chk("busy_done", 64'(busy), 0);

        // addi then j, base 0
        do_start(8'h00);
        chk("start_clr_done", 64'(done), 0);
        send(2'd1, 6'h08, 6'h00, 5'd0, 5'd8, 5'd0, 16'h0005, 26'h0,
             1'b0, 1'b1, 32'h2008_0005);
        send(2'd2, 6'h02, 6'h00, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10,
             1'b1, 1'b1, 32'h0800_0010);
        wait_done("done_ij");
        chk("cnt_ij", 64'(word_count), 2);

        // Backpressure: IMEM stalled, in_valid held for 10 cycles
        do_start(8'h20);
        mem_if.imem_ready = 1'b0;
        in_if.in_fmt = 2'd1;
        in_if.in_op = 6'h0D;
        in_if.in_rs = 5'd0;
        in_if.in_rt = 5'd1;
        in_if.in_imm = 16'd0;
        in_if.in_last = 1'b0;
        in_if.in_valid = 1'b1;
        accepted = 0;
        snap_addr = '0;
        snap_data = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 5) begin
                snap_addr = mem_if.imem_addr;
                snap_data = mem_if.imem_wdata;
            end
            if (i == 9) begin
                chk("stall_addr_hold", 64'(mem_if.imem_addr),
                    64'(snap_addr));
                chk("stall_data_hold", 64'(mem_if.imem_wdata),
                    64'(snap_data));
                chk("stall_addr", 64'(mem_if.imem_addr), 64'h20);
                chk("stall_data", 64'(mem_if.imem_wdata), 64'h3401_0000);
                chk("stall_we", 64'(mem_if.imem_we), 1);
            end
            if (in_if.in_ready) begin
                sb.push_back({exp_addr, 32'h3401_0000 + 32'(accepted)});
                exp_addr = exp_addr + 8'd1;
                accepted++;
            end
            @(posedge clk); #1;
            in_if.in_imm = 16'(accepted);
        end
        in_if.in_valid = 1'b0;
        chk("stall_accepted", 64'(accepted), 4);
        chk("full_ready", 64'(in_if.in_ready), 0);
        mem_if.imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("burst_we", 64'(mem_if.imem_we), 1);
        end
        @(negedge clk);
        chk("burst_end_we", 64'(mem_if.imem_we), 0);
        @(posedge clk); #1;
        send(2'd1, 6'h0D, 6'h00, 5'd0, 5'd1, 5'd0, 16'h0004, 26'h0,
             1'b1, 1'b1, 32'h3401_0004);
        wait_done("done_stall");
        chk("cnt_stall", 64'(word_count), 5);

        // Address wrap from 0xFF
        do_start(8'hFF);
        send(2'd1, 6'h0D, 6'h00, 5'd0, 5'd1, 5'd0, 16'h00AA, 26'h0,
             1'b0, 1'b1, 32'h3401_00AA);
        send(2'd1, 6'h0D, 6'h00, 5'd0, 5'd1, 5'd0, 16'h00BB, 26'h0,
             1'b1, 1'b1, 32'h3401_00BB);
        wait_done("done_wrap");
        chk("cnt_wrap", 64'(word_count), 2);

        // Illegal encodings are dropped but flagged
        do_start(8'h40);
        send(2'd3, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0,
             1'b0, 1'b0, 32'h0);
        chk("err_fmt3", 64'(err_illegal), 1);
        send(2'd0, 6'h04, 6'h20, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0,
             1'b0, 1'b0, 32'h0);
        send(2'd2, 6'h02, 6'h00, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FF_FFFF,
             1'b1, 1'b1, 32'h0BFF_FFFF);
        wait_done("done_illegal");
        chk("err_sticky", 64'(err_illegal), 1);
        chk("cnt_illegal", 64'(word_count), 1);
        do_start(8'h80);
        chk("err_cleared", 64'(err_illegal), 0);

        // Reset with three words parked in the FIFO
        mem_if.imem_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(2'd1, 6'h0D, 6'h00, 5'd0, 5'd1, 5'd0, 16'(i), 26'h0,
                 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("pre_rst_we", 64'(mem_if.imem_we), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_we", 64'(mem_if.imem_we), 0);
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_done", 64'(done), 0);
        chk("mid_rst_cnt", 64'(word_count), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_if.imem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_we", 64'(mem_if.imem_we), 0);
        end
        chk("post_rst_ready", 64'(in_if.in_ready), 0);
        chk("sb_empty", 64'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not end");
        $fatal(1);
    end

endmodule
